// File: rtl/bist_pkg.sv
// Shared definitions for the logic BIST controller: FSM state encoding and default
// LFSR/MISR polynomial masks.
package bist_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StRun  = 3'd2,
    StCmp  = 3'd3,
    StDone = 3'd4
  } bist_state_e;

  // x^5 + x^2 + 1, maximal length for a 5-bit Galois LFSR
  localparam logic [4:0] DefLfsrPoly = 5'h05;
  localparam logic [4:0] DefLfsrSeed = 5'h01;
  localparam logic [7:0] DefMisrPoly = 8'h1D;

endpackage

// File: rtl/logic_bist_ctrl_if.sv
// Handshake and CUT-pin bundle between test control / CUT and the BIST controller.
// BIST_ABORT_EN adds the abort request.
interface logic_bist_ctrl_if #(
  parameter int unsigned PI_W   = 5,
  parameter int unsigned PO_W   = 2,
  parameter int unsigned MISR_W = 8
) ();

  logic              start;
`ifdef BIST_ABORT_EN
  logic              abort;
`endif
  logic [PO_W-1:0]   cut_out;
  logic [PI_W-1:0]   cut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  // Environment side: test control plus the CUT output pins.
  modport master (
`ifdef BIST_ABORT_EN
    output abort,
`endif
    output start, cut_out,
    input  cut_in, busy, done, pass, signature
  );

  modport slave (
`ifdef BIST_ABORT_EN
    input  abort,
`endif
    input  start, cut_out,
    output cut_in, busy, done, pass, signature
  );

endinterface

// File: rtl/bist_galois_reg.sv
// Galois shift register with clear/load/shift and a parallel data input; serves as both
// pattern generator (data tied low) and signature compactor.
module bist_galois_reg #(
  parameter int unsigned     Width = 8,
  parameter logic [Width-1:0] Poly = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             shift_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[Width-2:0], 1'b0} ^ (q_q[Width-1] ? Poly : '0) ^ din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/logic_bist_ctrl.sv
// Logic BIST controller: LFSR patterns into the CUT, MISR compaction of its outputs, golden
// signature compare with start/done handshake. BIST_ABORT_EN adds an abort request.
module logic_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned       PI_W       = 5,
  parameter int unsigned       PO_W       = 2,
  parameter int unsigned       MISR_W     = 8,
  parameter int unsigned       NUM_PAT    = 31,
  parameter logic [PI_W-1:0]   LFSR_SEED  = DefLfsrSeed,
  parameter logic [PI_W-1:0]   LFSR_POLY  = DefLfsrPoly,
  parameter logic [MISR_W-1:0] MISR_POLY  = DefMisrPoly,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input logic               CP,
  input logic               CDN,
  logic_bist_ctrl_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(NUM_PAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_PAT - 1);
  // An all-zero seed would lock the LFSR; substitute 1.
  localparam logic [PI_W-1:0] SeedEff = (LFSR_SEED == '0) ? {{(PI_W-1){1'b0}}, 1'b1}
                                                           : LFSR_SEED;

  bist_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              reg_load, reg_shift;
  logic [PI_W-1:0]   lfsr;
  logic [MISR_W-1:0] misr;
  logic [MISR_W-1:0] misr_din;

  always_comb begin
    misr_din            = '0;
    misr_din[PO_W-1:0]  = bus.cut_out;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    reg_load  = 1'b0;
    reg_shift = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = StInit;
      end
      StInit: begin
        reg_load = 1'b1;
        cnt_d    = '0;
        pass_d   = 1'b0;
        state_d  = StRun;
      end
      StRun: begin
        reg_shift = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StCmp;
      end
      StCmp: begin
        pass_d  = (misr == GOLDEN_SIG);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
`ifdef BIST_ABORT_EN
    if (bus.abort && (state_q == StInit || state_q == StRun)) begin
      state_d = StIdle;
      pass_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  bist_galois_reg #(
    .Width (PI_W),
    .Poly  (LFSR_POLY)
  ) u_lfsr (
    .clk_i      (CP),
    .rst_ni     (CDN),
    .clear_i    (1'b0),
    .load_i     (reg_load),
    .load_val_i (SeedEff),
    .shift_i    (reg_shift),
    .din_i      ('0),
    .q_o        (lfsr)
  );

  bist_galois_reg #(
    .Width (MISR_W),
    .Poly  (MISR_POLY)
  ) u_misr (
    .clk_i      (CP),
    .rst_ni     (CDN),
    .clear_i    (reg_load),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (reg_shift),
    .din_i      (misr_din),
    .q_o        (misr)
  );

  assign bus.cut_in    = (state_q == StRun) ? lfsr : '0;
  assign bus.busy      = (state_q == StInit) || (state_q == StRun) || (state_q == StCmp);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = pass_q;
  assign bus.signature = misr;

endmodule
